tdm_demux: RTL
==============

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer: receives a serial slot stream (one DW-bit sample per
//  accepted beat, slot 0 marked by in_sof) and distributes the samples into N_CH
//  parallel channel registers. Publishes each complete frame atomically with a
//  one-cycle out_valid pulse. Sits at the receiving end of a slot-interleaved mux link.
// PARAMETERS
//  N_CH  2  channels (slots) per frame; legal range 2..16
//  DW    1  data width per channel, bits; >=1
// PORTS
//  clk        in   1        single clock, rising-edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        beat qualifier; in_sof/in_data ignored when 0
//  in_sof     in   1        start of frame: current beat is slot 0
//  in_data    in   DW       sample for current slot
//  out_data   out  N_CH*DW  published frame; channel k at [k*DW +: DW]
//  out_valid  out  1        1-cycle pulse: out_data just updated with a complete frame
//  err_frame  out  1        1-cycle pulse: framing error (only live with TDM_ERR_EN)
//  slot_idx   out  clog2(N_CH)  next slot expected (debug/status)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, slot_idx=0, shadow=0, out_data=0,
//    out_valid=0, err_frame=0. Deassertion is synchronised externally.
//  - Internal shadow register N_CH*DW; out_data is a separate holding register.
//  - FSM states: IDLE (waiting for sof), COLLECT (slots 1..N_CH-1 pending).
//  - IDLE: in_valid&in_sof -> shadow[0]=in_data, slot_idx=1, -> COLLECT.
//          in_valid&!in_sof -> beat dropped, stay IDLE (stray beat error).
//  - COLLECT: in_valid&!in_sof -> shadow[slot_idx]=in_data, slot_idx++.
//          When slot N_CH-1 is captured: out_data <= shadow with that last sample
//          merged, out_valid=1 next cycle, slot_idx=0, -> IDLE.
//          in_valid&in_sof (short frame) -> partial frame discarded, beat taken as
//          new slot 0 (shadow[0]=in_data, slot_idx=1), stay COLLECT; framing error.
//  - in_valid=0: no state change, gaps of any length allowed inside a frame.
//  - Latency: out_valid/out_data change exactly 1 clk after the beat carrying slot N_CH-1.
//  - Back-to-back frames: sof on the cycle right after the last slot is accepted
//    normally; out_valid pulses once per frame, never stretched.
//  - out_data holds last complete frame until next completion; partial frames never
//    visible on out_data. Unwritten shadow slots keep stale values (overwritten anyway).
//  - slot_idx wraps N_CH-1 -> 0 only via frame completion; never exceeds N_CH-1.
//  - Reset mid-frame: partial frame lost, out_data cleared to 0, no out_valid.
// CONFIGURATION
//  TDM_ERR_EN defined: err_frame pulses 1 clk after a stray beat in IDLE or a short
//   frame (sof in COLLECT); plus 8-bit saturating err_cnt (internal, reset 0, sticks
//   at 255) readable via hierarchy for debug.
//  TDM_ERR_EN undefined: err_frame tied 0, no counter; data path behaviour identical.
// TESTING  (bench: N_CH=4, DW=8, TDM_ERR_EN defined unless noted)
//  1 Reset: rst_n=0 mid-cycle -> out_data=0, out_valid=0, err_frame=0, slot_idx=0 at once.
//  2 Frame 11,22,33,44 (sof on 11), contiguous -> 1 clk after 44: out_valid=1 one cycle,
//    out_data=32'h44332211.
//  3 Same frame with 3 idle cycles between each beat -> identical out_data, single pulse.
//  4 Beats 55,66 then sof 77,88,99,AA -> err_frame pulse after 77, out_data=32'hAA998877,
//    previous out_data held until then.
//  5 Two frames back-to-back (01..04, 05..08) -> two out_valid pulses 4 clks apart,
//    out_data 32'h04030201 then 32'h08070605.
//  6 Stray beat 0x5A with sof=0 in IDLE -> dropped, err_frame=1 (0 when TDM_ERR_EN undefined),
//    slot_idx stays 0, out_data unchanged.

Source files
------------

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: gathers one sample per slot into a shadow frame and
// publishes complete frames atomically. Optional framing-error reporting: TDM_ERR_EN.
module tdm_demux #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned DW   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [DW-1:0]                in_data,
  output logic [N_CH*DW-1:0]           out_data,
  output logic                         out_valid,
  output logic                         err_frame,
  output logic [$clog2(N_CH)-1:0]      slot_idx
);

  localparam int unsigned SW = $clog2(N_CH);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StCollect = 1'b1;

  localparam logic [SW-1:0] LastSlot = SW'(N_CH - 1);

  logic [0:0]               state_q, state_d;
  logic [SW-1:0]            slot_q, slot_d;
  logic [N_CH-1:0][DW-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0][DW-1:0]  out_q, out_d;
  logic                     valid_q, valid_d;
  logic                     err_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (in_valid) begin
      case (state_q)
        StIdle: begin
          if (in_sof) begin
            shadow_d[0] = in_data;
            slot_d      = SW'(1);
            state_d     = StCollect;
          end else begin
            err_d = 1'b1;
          end
        end
        StCollect: begin
          if (in_sof) begin
            // Short frame: restart collection with this beat as slot 0.
            shadow_d[0] = in_data;
            slot_d      = SW'(1);
            err_d       = 1'b1;
          end else begin
            shadow_d[slot_q] = in_data;
            if (slot_q == LastSlot) begin
              out_d   = shadow_d;
              valid_d = 1'b1;
              slot_d  = '0;
              state_d = StIdle;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

`ifdef TDM_ERR_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      if (err_d && (err_cnt_q != 8'hff)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_frame = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
  assign err_frame  = 1'b0;
`endif

  assign out_data  = out_q;
  assign out_valid = valid_q;
  assign slot_idx  = slot_q;

endmodule
